sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-port round-robin arbiter in front of the SramController.
- Port A is the pipeline MEM stage; port B is a secondary master (program loader/debug).
- It serialises 32-bit read/write requests onto the single controller port, captures the request at grant, and returns per-port ready/readData.
- A watchdog aborts an access whose completion never arrives.

Parameters:
- DATA_W, 32, data width of requester and controller ports
- ADDR_W, 32, address width (byte address; the controller applies its own base offset)
- TIMEOUT, 63, max cycles in a BUSY state before abort; 6-bit counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_wr_en  in  1  port A write request
- a_rd_en  in  1  port A read request
- a_address  in  ADDR_W  port A address
- a_writeData  in  DATA_W  port A write data
- a_readData  out  DATA_W  port A read result, registered
- a_ready  out  1  port A ready; 0 = stall
- b_wr_en, b_rd_en, b_address, b_writeData, b_readData, b_ready: same as port A, for port B
- mem_wr_en  out  1  to controller wr_en
- mem_rd_en  out  1  to controller rd_en
- mem_address  out  ADDR_W  to controller address
- mem_writeData  out  DATA_W  to controller writeData
- mem_readData  in  DATA_W  from controller readData
- mem_ready  in  1  controller done; high in the completion cycle
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, last_grant = B (so A wins the first tie).
  - All mem_* outputs 0; both readData registers 0; timeout_err 0; watchdog counter 0.
  - Reset mid-access drops the access immediately; the controller is reset by the same rst.
- States: IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B.
- IDLE:
  - A port is requesting if its wr_en or rd_en is high.
  - Only one requester: grant it.
  - Both requesting: grant the port that is not last_grant.
  - On grant, register the address, writeData and op, then go to BUSY_X and set last_grant = X.
  - If both wr_en and rd_en are high, the op is a write.
- BUSY_X:
  - mem_wr_en or mem_rd_en is held at the captured op; mem_address and mem_writeData come from the captured registers.
  - Requester inputs are ignored.
  - The watchdog increments each cycle.
  - On mem_ready: latch mem_readData into x_readData (reads only; writes leave it unchanged), then go to DONE_X.
  - If the watchdog reaches TIMEOUT without mem_ready: set timeout_err, leave x_readData unchanged, go to DONE_X.
- DONE_X:
  - mem enables are 0 and x_ready = 1 for exactly one cycle.
  - Next state is IDLE.
  - The watchdog clears.
- Ready rule (combinational): x_ready = 0 while port X is requesting and not in DONE_X; otherwise 1. An idle port sees ready = 1.
- Latency:
  - Request seen in IDLE at cycle 0 → BUSY from cycle 1.
  - If mem_ready arrives at cycle k, then ready = 1 and readData is valid at cycle k+1.
  - Back-to-back requests from the same port add one IDLE cycle each.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, B; neither port waits more than one access.
- Requester obligation: after seeing ready = 1, the requester presents its next request or deasserts. A held request is treated as a new access.
- mem_ready outside a BUSY state is ignored.
- timeout_err clears only on rst.

Test Plan:
- After reset, A read from address 0x400 with the controller model returning 0xDEADBEEF after 5 cycles → mem_rd_en high cycles 1–5; a_ready = 0 until cycle 6, then a_ready = 1 and a_readData = 0xDEADBEEF; b_ready = 1 throughout.
- A and B both raise requests in the same cycle after reset (A write 0x11223344 @0x404, B read @0x408) → A is served first (mem_writeData = 0x11223344); B is granted at the next IDLE; b_ready stays 0 until its DONE cycle.
- Both ports requesting continuously for 4 accesses → grant order A, B, A, B; last_grant toggles each time.
- wr_en and rd_en both high on port B → mem_wr_en = 1, mem_rd_en = 0; b_readData unchanged.
- Controller model never asserts mem_ready → after 63 BUSY cycles timeout_err = 1, the port gets one ready pulse, state returns to IDLE; the next access completes normally and timeout_err stays 1.
- rst asserted during BUSY_A, then released → all mem_* outputs and timeout_err 0 immediately; state IDLE; on release, a still-asserted A request is re-granted.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of the SRAM controller
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   a_* / b_*                requester ports: wr_en, rd_en, address, writeData in;
//                            readData (registered) and ready (0 = stall) out
//                            port A = pipeline MEM stage, port B = loader/debug
//   mem_*                    single controller port: enables, address, writeData out;
//                            readData and ready (completion pulse) in
//   timeout_err              sticky watchdog flag, cleared only by rst
module sram_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_wr_en,
  input  logic              a_rd_en,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_writeData,
  output logic [DATA_W-1:0] a_readData,
  output logic              a_ready,
  input  logic              b_wr_en,
  input  logic              b_rd_en,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_writeData,
  output logic [DATA_W-1:0] b_readData,
  output logic              b_ready,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  input  logic              mem_ready,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_A = 3'd1,
    BUSY_B = 3'd2,
    DONE_A = 3'd3,
    DONE_B = 3'd4
  } state_t;

  state_t state, state_nx;

  logic              last_b;     // 1 = most recent grant went to port B
  logic              cap_wr;     // captured op: 1 = write, 0 = read
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [5:0]        wd_cnt;

  logic a_req, b_req, grant_a, grant_b, busy, wd_expire;

  assign a_req = a_wr_en | a_rd_en;
  assign b_req = b_wr_en | b_rd_en;

  // A wins a tie unless it was the last port served.
  assign grant_a = a_req & (~b_req | last_b);
  assign grant_b = b_req & ~grant_a;

  assign busy = (state == BUSY_A) || (state == BUSY_B);

  // Counter reads 0 in the first BUSY cycle, so hitting TIMEOUT-1 means
  // TIMEOUT busy cycles have elapsed by the end of this one.
  assign wd_expire = (wd_cnt == 6'(TIMEOUT - 1));

  // A port is stalled while it requests, except in its own DONE cycle.
  assign a_ready = ~(a_req && (state != DONE_A));
  assign b_ready = ~(b_req && (state != DONE_B));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_a)      state_nx = BUSY_A;
        else if (grant_b) state_nx = BUSY_B;
      end
      BUSY_A:  if (mem_ready || wd_expire) state_nx = DONE_A;
      BUSY_B:  if (mem_ready || wd_expire) state_nx = DONE_B;
      DONE_A:  state_nx = IDLE;
      DONE_B:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Controller drive is gated by BUSY so nothing leaks out in IDLE/DONE.
  always_comb begin
    mem_wr_en     = 1'b0;
    mem_rd_en     = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    if (busy) begin
      mem_wr_en     = cap_wr;
      mem_rd_en     = ~cap_wr;
      mem_address   = cap_addr;
      mem_writeData = cap_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b      <= 1'b1;
      cap_wr      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      wd_cnt      <= '0;
      a_readData  <= '0;
      b_readData  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && (grant_a || grant_b)) begin
        last_b    <= grant_b;
        // Write wins when both enables are high.
        cap_wr    <= grant_a ? a_wr_en : b_wr_en;
        cap_addr  <= grant_a ? a_address : b_address;
        cap_wdata <= grant_a ? a_writeData : b_writeData;
      end

      // Count only while staying in BUSY; leaving BUSY clears it.
      if (busy && (state_nx == state)) begin
        wd_cnt <= wd_cnt + 6'd1;
      end else begin
        wd_cnt <= '0;
      end

      if (busy && mem_ready && !cap_wr) begin
        if (state == BUSY_A) a_readData <= mem_readData;
        else                 b_readData <= mem_readData;
      end

      if (busy && !mem_ready && wd_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        a_wr_en, a_rd_en;
  logic [31:0] a_address, a_writeData, a_readData;
  logic        a_ready;
  logic        b_wr_en, b_rd_en;
  logic [31:0] b_address, b_writeData, b_readData;
  logic        b_ready;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_ready;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;

  sram_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst),
    .a_wr_en(a_wr_en), .a_rd_en(a_rd_en), .a_address(a_address),
    .a_writeData(a_writeData), .a_readData(a_readData), .a_ready(a_ready),
    .b_wr_en(b_wr_en), .b_rd_en(b_rd_en), .b_address(b_address),
    .b_writeData(b_writeData), .b_readData(b_readData), .b_ready(b_ready),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData),
    .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Everything is driven and sampled on the falling edge.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_wr_en = 0; a_rd_en = 0; a_address = 0; a_writeData = 0;
    b_wr_en = 0; b_rd_en = 0; b_address = 0; b_writeData = 0;
    mem_readData = 0; mem_ready = 0;
    nxt(); nxt();

    // Reset state
    check("rst_mem_wr", {31'd0, mem_wr_en}, 0);
    check("rst_mem_rd", {31'd0, mem_rd_en}, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_mem_wdata", mem_writeData, 0);
    check("rst_a_rdata", a_readData, 0);
    check("rst_b_rdata", b_readData, 0);
    check("rst_tmo", {31'd0, timeout_err}, 0);
    check("rst_a_ready", {31'd0, a_ready}, 1);
    check("rst_b_ready", {31'd0, b_ready}, 1);
    rst = 1'b0;

    // Single A read, completion on cycle 5
    a_rd_en = 1; a_address = 32'h400;
    #1 check("t1_a_ready_c0", {31'd0, a_ready}, 0);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      check("t1_mem_rd", {31'd0, mem_rd_en}, 1);
      check("t1_mem_addr", mem_address, 32'h400);
      check("t1_a_stall", {31'd0, a_ready}, 0);
      check("t1_b_ready", {31'd0, b_ready}, 1);
      if (i == 5) begin
        mem_ready = 1; mem_readData = 32'hDEADBEEF;
      end
    end
    nxt();
    mem_ready = 0;
    check("t1_a_ready_c6", {31'd0, a_ready}, 1);
    check("t1_a_rdata", a_readData, 32'hDEADBEEF);
    check("t1_mem_rd_off", {31'd0, mem_rd_en}, 0);
    a_rd_en = 0;

    // Simultaneous requests right after reset: A wins the tie
    rst = 1; #1 rst = 0;
    a_wr_en = 1; a_address = 32'h404; a_writeData = 32'h11223344;
    b_rd_en = 1; b_address = 32'h408;
    nxt();
    check("t2_mem_wr", {31'd0, mem_wr_en}, 1);
    check("t2_mem_rd", {31'd0, mem_rd_en}, 0);
    check("t2_mem_wdata", mem_writeData, 32'h11223344);
    check("t2_mem_addr", mem_address, 32'h404);
    check("t2_b_stall1", {31'd0, b_ready}, 0);
    mem_ready = 1;
    nxt();
    mem_ready = 0;
    check("t2_a_done", {31'd0, a_ready}, 1);
    check("t2_b_stall2", {31'd0, b_ready}, 0);
    a_wr_en = 0;
    nxt();
    check("t2_idle_rd", {31'd0, mem_rd_en}, 0);
    check("t2_b_stall3", {31'd0, b_ready}, 0);
    nxt();
    check("t2_b_mem_rd", {31'd0, mem_rd_en}, 1);
    check("t2_b_addr", mem_address, 32'h408);
    check("t2_b_stall4", {31'd0, b_ready}, 0);
    mem_ready = 1; mem_readData = 32'hCAFEF00D;
    nxt();
    mem_ready = 0;
    check("t2_b_done", {31'd0, b_ready}, 1);
    check("t2_b_rdata", b_readData, 32'hCAFEF00D);
    check("t2_a_rdata_kept", a_readData, 32'h0);
    b_rd_en = 0;
    nxt();

    // Fairness: both continuously reading, expect A, B, A, B
    a_rd_en = 1; a_address = 32'h10;
    b_rd_en = 1; b_address = 32'h20;
    for (int k = 0; k < 4; k++) begin
      nxt();
      check("t3_grant_addr", mem_address, (k % 2 == 0) ? 32'h10 : 32'h20);
      mem_ready = 1; mem_readData = 32'hA0000000 + k;
      nxt();
      mem_ready = 0;
      check("t3_a_ready", {31'd0, a_ready}, (k % 2 == 0) ? 1 : 0);
      check("t3_b_ready", {31'd0, b_ready}, (k % 2 == 0) ? 0 : 1);
      nxt();
    end
    a_rd_en = 0; b_rd_en = 0;
    check("t3_a_rdata", a_readData, 32'hA0000002);
    check("t3_b_rdata", b_readData, 32'hA0000003);

    // Port B with both enables: treated as a write
    b_wr_en = 1; b_rd_en = 1; b_address = 32'h30; b_writeData = 32'h55AA55AA;
    mem_readData = 32'h99999999;
    nxt();
    check("t4_mem_wr", {31'd0, mem_wr_en}, 1);
    check("t4_mem_rd", {31'd0, mem_rd_en}, 0);
    check("t4_mem_wdata", mem_writeData, 32'h55AA55AA);
    mem_ready = 1;
    nxt();
    mem_ready = 0;
    check("t4_b_done", {31'd0, b_ready}, 1);
    check("t4_b_rdata_kept", b_readData, 32'hA0000003);
    b_wr_en = 0; b_rd_en = 0;
    nxt();

    // Watchdog: A read never completes
    a_rd_en = 1; a_address = 32'h500;
    repeat (63) nxt();
    check("t5_busy63_rd", {31'd0, mem_rd_en}, 1);
    check("t5_busy63_tmo", {31'd0, timeout_err}, 0);
    check("t5_busy63_stall", {31'd0, a_ready}, 0);
    nxt();
    check("t5_tmo_set", {31'd0, timeout_err}, 1);
    check("t5_done_ready", {31'd0, a_ready}, 1);
    check("t5_done_rd_off", {31'd0, mem_rd_en}, 0);
    check("t5_rdata_kept", a_readData, 32'hA0000002);
    a_rd_en = 0;
    nxt();
    check("t5_idle_rd", {31'd0, mem_rd_en}, 0);
    a_rd_en = 1; a_address = 32'h504;
    nxt();
    check("t5_next_addr", mem_address, 32'h504);
    mem_ready = 1; mem_readData = 32'h12345678;
    nxt();
    mem_ready = 0;
    check("t5_next_ready", {31'd0, a_ready}, 1);
    check("t5_next_rdata", a_readData, 32'h12345678);
    check("t5_tmo_sticky", {31'd0, timeout_err}, 1);
    a_rd_en = 0;
    nxt();

    // Reset during BUSY_A, request still held afterwards
    a_rd_en = 1; a_address = 32'h600;
    nxt();
    check("t6_busy_rd", {31'd0, mem_rd_en}, 1);
    #2 rst = 1;
    #1;
    check("t6_rst_rd", {31'd0, mem_rd_en}, 0);
    check("t6_rst_addr", mem_address, 0);
    check("t6_rst_tmo", {31'd0, timeout_err}, 0);
    check("t6_rst_a_rdata", a_readData, 0);
    nxt();
    rst = 0;
    nxt();
    check("t6_regrant_rd", {31'd0, mem_rd_en}, 1);
    check("t6_regrant_addr", mem_address, 32'h600);
    mem_ready = 1; mem_readData = 32'h0BADF00D;
    nxt();
    mem_ready = 0;
    check("t6_done_ready", {31'd0, a_ready}, 1);
    check("t6_done_rdata", a_readData, 32'h0BADF00D);
    a_rd_en = 0;
    nxt();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
